// File: rtl/rvfi_commit_serializer.sv
// Compacts up to CH retirements per cycle into a circular buffer and drains
// them one per cycle in program order, with overflow/order-gap flags.
module rvfi_commit_serializer #(
  parameter int CH    = 8,
  parameter int DEPTH = 16,
  parameter int PKT_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH-1:0]            in_valid,
  input  logic [CH*64-1:0]         in_order,
  input  logic [CH*PKT_W-1:0]      in_pkt,
  output logic                     stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_order,
  output logic [PKT_W-1:0]         out_pkt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     order_err,
  output logic [63:0]              commit_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(CH + 1);

  logic [63:0]      order_mem [DEPTH];
  logic [PKT_W-1:0] pkt_mem   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   exp_order;

  logic [NW-1:0] n_lanes;
  logic [AW-1:0] lane_off [CH];
  logic [AW-1:0] off_acc;
  logic [CW:0]   need;
  logic          accept;
  logic          drop;
  logic          hs;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    n_lanes = '0;
    off_acc = '0;
    for (int i = 0; i < CH; i++) begin
      lane_off[i] = off_acc;
      off_acc     = off_acc + AW'(in_valid[i]);
      n_lanes     = n_lanes + NW'(in_valid[i]);
    end
  end

  // Admission uses the registered count only; a same-cycle dequeue does not help.
  always_comb begin
    need   = {1'b0, count} + (CW+1)'(n_lanes);
    accept = (n_lanes != '0) && (need <= (CW+1)'(DEPTH));
    drop   = (n_lanes != '0) && !accept;
  end

  assign out_valid = (count != '0);
  assign hs        = out_valid & out_ready;
  assign out_order = order_mem[rd_ptr];
  assign out_pkt   = pkt_mem[rd_ptr];
  assign stall     = (count > CW'(DEPTH - CH));

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < CH; i++) begin
        if (in_valid[i]) begin
          order_mem[wr_ptr + lane_off[i]] <= in_order[i*64 +: 64];
          pkt_mem[wr_ptr + lane_off[i]]   <= in_pkt[i*PKT_W +: PKT_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      commit_cnt   <= '0;
      exp_order    <= '0;
      overflow_err <= 1'b0;
      order_err    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(n_lanes);
      if (hs) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (accept ? CW'(n_lanes) : CW'(0)) - CW'(hs);
      if (drop) overflow_err <= 1'b1;
      if (hs) begin
        commit_cnt <= commit_cnt + 64'd1;
        // Resync to the observed order so a single gap flags only once.
        exp_order  <= out_order + 64'd1;
        if (out_order != exp_order) order_err <= 1'b1;
      end
    end
  end

endmodule
